// File: rtl/seq_dp_pkg.sv
// Shared types and encodings for the sequenced datapath: FSM states,
// ALU operation codes and B-path shift codes.
package seq_dp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/seq_dp_regfile.sv
// Register file for seq_datapath: NREG x W, one synchronous write port that is
// cleared by reset, one operand read port and one debug read port (both
// combinational).
module seq_dp_regfile
  import seq_dp_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [RW-1:0] ra,
  output logic [W-1:0]  rdata,
  input  logic [RW-1:0] dbg_ra,
  output logic [W-1:0]  dbg_rdata
);

  logic [W-1:0] regs [NREG];

  // Storage: reset clears every register, otherwise write-back when enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rdata     = regs[ra];
  assign dbg_rdata = regs[dbg_ra];

endmodule

// File: rtl/seq_datapath.sv
// Sequenced datapath: a single start pulse carries Rd <- Rn op shift(Rm) or
// Rd <- immediate through IDLE/LOADA/LOADB/EXEC/WB and pulses done after
// write-back. Shifter and ALU are inline.
// Optional build macro SEQ_DP_NOWB_EN adds a nowb input that suppresses the
// register write of ALU commands (compare semantics).
module seq_datapath
  import seq_dp_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          imm_sel,
  input  logic [W-1:0]  imm_in,
  input  logic [1:0]    op,
  input  logic [1:0]    shift,
  input  logic [RW-1:0] rd,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
`ifdef SEQ_DP_NOWB_EN
  input  logic          nowb,
`endif
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          Z,
  output logic          N,
  output logic          V,
  input  logic [RW-1:0] dbg_rnum,
  output logic [W-1:0]  dbg_rdata
);

  // B-path shifter; lsl drops the MSB, lsr zero-fills, asr keeps the sign
  function automatic logic signed [W-1:0] shift_fn(input logic [1:0] sh,
                                                   input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    case (sh)
      SH_LSL:  r = {b[W-2:0], 1'b0};
      SH_LSR:  r = {1'b0, b[W-1:1]};
      SH_ASR:  r = b >>> 1;
      default: r = b;
    endcase
    return r;
  endfunction

  // ALU returning {overflow, result}; overflow only meaningful for add/sub
  function automatic logic [W:0] alu_fn(input logic [1:0] f,
                                        input logic signed [W-1:0] a,
                                        input logic signed [W-1:0] b);
    logic signed [W-1:0] c;
    logic                v;
    c = '0;
    v = 1'b0;
    case (f)
      ALU_ADD: begin
        c = a + b;
        v = (a[W-1] == b[W-1]) && (c[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        c = a - b;
        v = (a[W-1] != b[W-1]) && (c[W-1] != a[W-1]);
      end
      ALU_AND: c = a & b;
      default: c = ~b;
    endcase
    return {v, c};
  endfunction

  state_e state_q, state_d;

  logic [1:0]    op_q, sh_q;
  logic [RW-1:0] rd_q, rn_q, rm_q;
  logic          imm_sel_q;
  logic [W-1:0]  imm_q;
  logic          nowb_q;

  logic signed [W-1:0] a_reg, b_reg, c_reg;
  logic signed [W-1:0] b_sh;
  logic [W:0]          alu_out;

  logic          cmd_cap, load_a, load_b, load_c, rf_we;
  logic [RW-1:0] rf_ra;
  logic [W-1:0]  rf_wd, rf_rdata;

  // State register and registered done pulse (set on the write-back edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == WB);
    end
  end

  // Next-state: fixed walk for ALU commands, straight to WB for immediates
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = imm_sel ? WB : LOADA;
      LOADA:   state_d = LOADB;
      LOADB:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: datapath strobes, operand read address and write-back
  always_comb begin
    busy    = (state_q != IDLE);
    cmd_cap = (state_q == IDLE) && start;
    load_a  = (state_q == LOADA);
    load_b  = (state_q == LOADB);
    load_c  = (state_q == EXEC);
    rf_ra   = (state_q == LOADB) ? rm_q : rn_q;
    rf_wd   = imm_sel_q ? imm_q : c_reg;
    rf_we   = (state_q == WB) && (imm_sel_q || !nowb_q);
  end

  // Command capture while idle; these hold the whole operation until WB
  always_ff @(posedge clk) begin
    if (cmd_cap) begin
      op_q      <= op;
      sh_q      <= shift;
      rd_q      <= rd;
      rn_q      <= rn;
      rm_q      <= rm;
      imm_sel_q <= imm_sel;
      imm_q     <= imm_in;
    end
  end

`ifdef SEQ_DP_NOWB_EN
  // Compare-mode flag travels with the command
  always_ff @(posedge clk) begin
    if (cmd_cap) nowb_q <= nowb;
  end
`else
  assign nowb_q = 1'b0;
`endif

  assign b_sh    = shift_fn(sh_q, b_reg);
  assign alu_out = alu_fn(op_q, a_reg, b_sh);

  // Operand, result and flag registers; flags and C move only in EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      c_reg <= '0;
      Z     <= 1'b0;
      N     <= 1'b0;
      V     <= 1'b0;
    end else begin
      if (load_a) a_reg <= rf_rdata;
      if (load_b) b_reg <= rf_rdata;
      if (load_c) begin
        c_reg <= alu_out[W-1:0];
        Z     <= (alu_out[W-1:0] == '0);
        N     <= alu_out[W-1];
        V     <= alu_out[W];
      end
    end
  end

  assign result = c_reg;

  seq_dp_regfile #(
    .W    (W),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (rf_we),
    .wa        (rd_q),
    .wd        (rf_wd),
    .ra        (rf_ra),
    .rdata     (rf_rdata),
    .dbg_ra    (dbg_rnum),
    .dbg_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath (W=16, NREG=8) with a scoreboard of
// expected command outcomes popped on each done pulse.
module tb_seq_datapath;

  localparam int W    = 16;
  localparam int NREG = 8;
  localparam int RW   = 3;

  logic          clk = 1'b0;
  logic          reset, start, imm_sel;
  logic [W-1:0]  imm_in;
  logic [1:0]    op, shift;
  logic [RW-1:0] rd, rn, rm, dbg_rnum;
`ifdef SEQ_DP_NOWB_EN
  logic          nowb;
`endif
  logic          busy, done, Z, N, V;
  logic [W-1:0]  result, dbg_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [RW-1:0] rd;
    logic [W-1:0]  c;
    logic          z, n, v;
    int            lat;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] mreg [NREG];
  logic [W-1:0] mc;
  logic         mz, mn, mv;

  always #5 clk = ~clk;

  seq_datapath #(.W(W), .NREG(NREG)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imm_sel   (imm_sel),
    .imm_in    (imm_in),
    .op        (op),
    .shift     (shift),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
`ifdef SEQ_DP_NOWB_EN
    .nowb      (nowb),
`endif
    .busy      (busy),
    .done      (done),
    .result    (result),
    .Z         (Z),
    .N         (N),
    .V         (V),
    .dbg_rnum  (dbg_rnum),
    .dbg_rdata (dbg_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_reg(input logic [RW-1:0] idx, output logic [W-1:0] val);
    dbg_rnum = idx;
    #1;
    val = dbg_rdata;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mreg[i] = '0;
    mc = '0; mz = 1'b0; mn = 1'b0; mv = 1'b0;
    sbq.delete();
  endtask

  // Drive one command across its accepting edge and push its expected outcome
  task automatic send(input logic is_imm, input logic [W-1:0] imm,
                      input logic [1:0] o, input logic [1:0] s,
                      input logic [RW-1:0] d, input logic [RW-1:0] n_,
                      input logic [RW-1:0] m, input logic nw);
    int a, b, bs, sa, sb, r;
    exp_t e;
    start = 1'b1; imm_sel = is_imm; imm_in = imm; op = o; shift = s;
    rd = d; rn = n_; rm = m;
`ifdef SEQ_DP_NOWB_EN
    nowb = nw;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    if (is_imm) begin
      mreg[d] = imm;
      e.lat = 1;
    end else begin
      a = int'(mreg[n_]);
      b = int'(mreg[m]);
      case (s)
        2'd1:    bs = (b * 2) % 65536;
        2'd2:    bs = b / 2;
        2'd3:    bs = b / 2 + ((b >= 32768) ? 32768 : 0);
        default: bs = b;
      endcase
      sa = (a >= 32768) ? a - 65536 : a;
      sb = (bs >= 32768) ? bs - 65536 : bs;
      mv = 1'b0;
      case (o)
        2'd0: begin r = sa + sb; mv = (r > 32767) || (r < -32768); end
        2'd1: begin r = sa - sb; mv = (r > 32767) || (r < -32768); end
        2'd2: r = a & bs;
        default: r = 65535 - bs;
      endcase
      mc = 16'(r & 32'hFFFF);
      mz = (mc == 16'h0000);
      mn = mc[15];
      if (!nw) mreg[d] = mc;
      e.lat = 4;
    end
    e.rd = d; e.c = mc; e.z = mz; e.n = mn; e.v = mv;
    sbq.push_back(e);
  endtask

  // Wait (bounded) for done, then pop the scoreboard and compare everything
  task automatic wait_done(input int start_cnt);
    int cnt;
    bit seen;
    exp_t e;
    logic [W-1:0] val;
    cnt = start_cnt;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (seen) check("latency", cnt, e.lat);
      check("result", 32'(result), 32'(e.c));
      check("Z", 32'(Z), 32'(e.z));
      check("N", 32'(N), 32'(e.n));
      check("V", 32'(V), 32'(e.v));
      read_reg(e.rd, val);
      check("rd_value", 32'(val), 32'(mreg[e.rd]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] val;
    int dcnt;
    reset = 1'b1; start = 1'b0; imm_sel = 1'b0; imm_in = '0;
    op = '0; shift = '0; rd = '0; rn = '0; rm = '0; dbg_rnum = '0;
`ifdef SEQ_DP_NOWB_EN
    nowb = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({Z, N, V}), 32'd0);
    for (int i = 0; i < NREG; i++) begin
      read_reg(RW'(i), val);
      check("rst_reg", 32'(val), 32'd0);
    end

    // MOV R0=7, MOV R1=2, ADD R2 = R1 + lsl1(R0)
    send(1'b1, 16'd7, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0); wait_done(0);
    send(1'b1, 16'd2, 2'd0, 2'd0, 3'd1, 3'd0, 3'd0, 1'b0); wait_done(0);
    send(1'b0, 16'd0, 2'b00, 2'b01, 3'd2, 3'd1, 3'd0, 1'b0); wait_done(0);
    read_reg(3'd2, val);
    check("add_r2", 32'(val), 32'h0010);
    check("add_flags", 32'({Z, N, V}), 32'd0);

    // Signed overflow on subtract
    send(1'b1, 16'h8000, 2'd0, 2'd0, 3'd3, 3'd0, 3'd0, 1'b0); wait_done(0);
    send(1'b1, 16'h0001, 2'd0, 2'd0, 3'd4, 3'd0, 3'd0, 1'b0); wait_done(0);
    send(1'b0, 16'd0, 2'b01, 2'b00, 3'd5, 3'd3, 3'd4, 1'b0); wait_done(0);
    check("sub_r5", 32'(result), 32'h7FFF);
    check("sub_flags", 32'({Z, N, V}), 32'b001);

    // Zero result, then an immediate leaves flags alone
    send(1'b0, 16'd0, 2'b01, 2'b00, 3'd6, 3'd0, 3'd0, 1'b0); wait_done(0);
    check("sub0_Z", 32'(Z), 32'd1);
    send(1'b1, 16'h1234, 2'd0, 2'd0, 3'd7, 3'd0, 3'd0, 1'b0); wait_done(0);
    check("mov_keepZ", 32'(Z), 32'd1);
    read_reg(3'd7, val);
    check("mov_r7", 32'(val), 32'h1234);

    // NOT of asr1(0x8000), AND with lsr1
    send(1'b0, 16'd0, 2'b11, 2'b11, 3'd1, 3'd0, 3'd3, 1'b0); wait_done(0);
    check("not_r1", 32'(result), 32'h3FFF);
    check("not_N", 32'(N), 32'd0);
    send(1'b0, 16'd0, 2'b10, 2'b10, 3'd4, 3'd0, 3'd2, 1'b0); wait_done(0);
    check("and_Z", 32'(Z), 32'd1);

    // A second start during LOADB must be ignored
    send(1'b0, 16'd0, 2'b00, 2'b00, 3'd5, 3'd0, 3'd7, 1'b0);
    @(posedge clk);
    #1;
    check("ign_busy", 32'(busy), 32'd1);
    start = 1'b1; imm_sel = 1'b1; imm_in = 16'hDEAD; rd = 3'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("ign_extra_done", dcnt, 0);
    read_reg(3'd6, val);
    check("ign_r6", 32'(val), 32'(mreg[6]));

    // Back-to-back random commands, each issued in the previous done cycle
    for (int i = 0; i < 14; i++) begin
      send(1'($urandom_range(0, 3) == 0), 16'($urandom),
           2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0);
      wait_done(0);
    end
    send(1'b1, 16'h7FFF, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0); wait_done(0);
    send(1'b0, 16'd0, 2'b00, 2'b00, 3'd1, 3'd0, 3'd0, 1'b0); wait_done(0);
    check("add_ovf_V", 32'(V), 32'd1);

`ifdef SEQ_DP_NOWB_EN
    // Compare mode: flags update, register untouched
    send(1'b1, 16'h0055, 2'd0, 2'd0, 3'd3, 3'd0, 3'd0, 1'b1); wait_done(0);
    send(1'b0, 16'd0, 2'b01, 2'b00, 3'd3, 3'd3, 3'd3, 1'b1); wait_done(0);
    check("nowb_Z", 32'(Z), 32'd1);
    read_reg(3'd3, val);
    check("nowb_r3", 32'(val), 32'h0055);
`endif

    // Reset while in EXEC aborts the command
    send(1'b0, 16'd0, 2'b00, 2'b00, 3'd2, 3'd0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    for (int i = 0; i < NREG; i++) begin
      read_reg(RW'(i), val);
      check("abort_reg", 32'(val), 32'd0);
    end
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
- Parametrised successor to the lab datapath: a register file, A/B operand registers, a B-path shifter, an ALU, a C result register and status flags.
- Adds an internal sequencer: one `start` pulse carries a full operation (Rd ← Rn op shift(Rm), or Rd ← immediate), executes over fixed cycles and signals `done`.
- Sits between the future instruction decoder and the register state; it replaces hand-driven loada/loadb/loadc/write control.

Parameters:
- W, 16, datapath and register width (≥4)
- NREG, 8, number of registers (power of two, ≥2); RW = $clog2(NREG)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command valid; sampled only when busy=0
- imm_sel  in  1  1 = write imm_in to Rd (MOV immediate); 0 = ALU operation
- imm_in  in  W  immediate value
- op  in  2  ALUop: 00 add, 01 sub (A−B), 10 and, 11 not B
- shift  in  2  shift on B: 00 none, 01 lsl1, 10 lsr1 (zero fill), 11 asr1
- rd, rn, rm  in  RW each  destination, A-source and B-source register numbers
- busy  out  1  high whenever state≠IDLE
- done  out  1  one-cycle pulse when the write-back edge completes
- result  out  W  C register
- Z, N, V  out  1 each  status flags
- dbg_rnum  in  RW  debug read address
- dbg_rdata  out  W  combinational read of register[dbg_rnum]

Behaviour:
- Reset: state=IDLE; A, B, C, Z, N, V, done = 0; all NREG registers cleared to 0. Reset mid-operation aborts the command with no register write and no done pulse.
- FSM states: IDLE, LOADA, LOADB, EXEC, WB.
- Command capture: start=1 in IDLE latches op, shift, rd, rn, rm, imm_sel and imm_in.
  - If imm_sel=0, the next state is LOADA.
  - If imm_sel=1, the next state is WB.
- LOADA: A ← reg[rn]; go to LOADB.
- LOADB: B ← reg[rm]; go to EXEC.
- EXEC:
  - C ← ALU(A, shift(B)).
  - Z = (C==0); N = C[W−1].
  - V = signed overflow for add/sub, 0 for and/not.
  - Go to WB.
- WB:
  - reg[rd] ← C, or the captured imm_in if imm_sel.
  - done=1 in the following cycle; return to IDLE.
- Latency, counting edges after the accepting edge:
  - ALU command: register written at edge 4, done high in the cycle after edge 4.
  - Immediate command: register written at edge 1, done high in the cycle after edge 1.
- Flags and C update only in EXEC; immediate commands leave Z/N/V/C unchanged.
- start while busy is ignored; no queueing.
  - start in the done cycle is accepted, since state is IDLE then.
- Operands are latched before write-back, so rd==rn==rm is legal.
- Arithmetic is modulo 2^W.
- Shift edge cases:
  - lsl1 discards the MSB.
  - asr1 replicates B[W−1].
  - Shift is applied only to the B operand.
- dbg_rdata reflects a WB write from the edge after that write.

Optional Feature:
- Macro: SEQ_DP_NOWB_EN.
- When defined:
  - Adds input port nowb (1 bit), latched with the command.
  - If nowb=1 on an ALU command, WB performs no register write (compare semantics); flags and C still update and done still pulses.
  - nowb is ignored for immediate commands.
- When undefined: the port is absent and write-back is always performed.

Decomposition:
- Package seq_dp_pkg holds:
  - state enum (IDLE, LOADA, LOADB, EXEC, WB);
  - ALUop constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT);
  - shift constants (SH_NONE, SH_LSL, SH_LSR, SH_ASR).
- Sub-module seq_dp_regfile, parametrised (W, NREG):
  - synchronous write with synchronous clear on reset;
  - two combinational read ports (operand and debug).
- Shifter and ALU stay inline in seq_datapath.

Test Plan:
- MOV R0=7, MOV R1=2; ADD rd=2, rn=1, rm=0, shift=01 → R2=16 (0x0010), Z=0, N=0, V=0; done pulses 4 edges after acceptance.
- MOV R3=0x8000, MOV R4=1; SUB rd=5, rn=3, rm=4 → R5=0x7FFF, V=1, N=0, Z=0.
- SUB rd=6, rn=0, rm=0 (R0=7) → R6=0, Z=1; a following MOV R7=0x1234 leaves Z=1.
- NOT rd=1, rm=3 (0x8000), shift=11 → B=0xC000, R1=0x3FFF, N=0; AND R0(7) with R2(16) lsr1 → 0, Z=1.
- Pulse start during LOADB with a different rd → ignored; only the first command writes, exactly one done pulse.
- Assert reset in EXEC → busy=0 next cycle, all registers 0, no done pulse. With SEQ_DP_NOWB_EN: SUB nowb=1 of R3−R3 → Z=1, R3 unchanged.
